// File: rtl/prog_loader.sv
// Boot-time program loader: parses a little-endian {N_I, imem words, N_D, dmem words}
// byte stream, writes both memories word by word, then releases and starts the core.
module prog_loader #(
  parameter int IADDR_WIDTH = 16,
  parameter int DADDR_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [7:0]             RX_DATA,
  input  logic                   RX_VALID,
  output logic                   RX_READY,
  output logic                   IMEM_WE,
  output logic [IADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [31:0]            IMEM_WDATA,
  output logic                   DMEM_WE,
  output logic [DADDR_WIDTH-1:0] DMEM_ADDR,
  output logic [31:0]            DMEM_WDATA,
  output logic                   CORE_RSTn,
  output logic                   CORE_EN,
  output logic                   START,
  output logic                   LOAD_ERR,
  output logic [31:0]            INSTR_CNT,
  output logic [31:0]            DATA_CNT
);

  // state     | meaning
  // S_I_HDR   | collecting 4-byte instruction word count
  // S_I_WORDS | assembling and writing instruction words
  // S_D_HDR   | collecting 4-byte data word count
  // S_D_WORDS | assembling and writing data words
  // S_RUN     | load done, core released (terminal)
  // S_ERR     | header too large for memory (terminal)
  localparam logic [2:0] S_I_HDR   = 3'd0;
  localparam logic [2:0] S_I_WORDS = 3'd1;
  localparam logic [2:0] S_D_HDR   = 3'd2;
  localparam logic [2:0] S_D_WORDS = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [32:0] I_LIMIT = 33'd1 << IADDR_WIDTH;
  localparam logic [32:0] D_LIMIT = 33'd1 << DADDR_WIDTH;

  logic [2:0]  state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [31:0] word_full;
  logic [31:0] word_idx;
  logic [31:0] words_left;
  logic        accept;
  logic        word_done;
  logic        loading_nxt;

  assign accept    = RX_VALID && RX_READY;
  // Bytes shift in from the top, so after four bytes byte j sits at [8j+7:8j].
  assign word_full = {RX_DATA, asm_word[31:8]};
  assign word_done = accept && (byte_cnt == 2'd3);

  always_comb begin
    state_nxt = state;
    case (state)
      S_I_HDR:
        if (word_done) begin
          if ({1'b0, word_full} > I_LIMIT) state_nxt = S_ERR;
          else if (word_full == 32'd0)     state_nxt = S_D_HDR;
          else                             state_nxt = S_I_WORDS;
        end
      S_I_WORDS:
        if (word_done && (words_left == 32'd1)) state_nxt = S_D_HDR;
      S_D_HDR:
        if (word_done) begin
          if ({1'b0, word_full} > D_LIMIT) state_nxt = S_ERR;
          else if (word_full == 32'd0)     state_nxt = S_RUN;
          else                             state_nxt = S_D_WORDS;
        end
      S_D_WORDS:
        if (word_done && (words_left == 32'd1)) state_nxt = S_RUN;
      default:
        state_nxt = state;
    endcase
  end

  assign loading_nxt = (state_nxt == S_I_HDR) || (state_nxt == S_I_WORDS) ||
                       (state_nxt == S_D_HDR) || (state_nxt == S_D_WORDS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_I_HDR;
      byte_cnt   <= 2'd0;
      asm_word   <= 32'd0;
      word_idx   <= 32'd0;
      words_left <= 32'd0;
      RX_READY   <= 1'b0;
      IMEM_WE    <= 1'b0;
      IMEM_ADDR  <= '0;
      IMEM_WDATA <= 32'd0;
      DMEM_WE    <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= 32'd0;
      CORE_RSTn  <= 1'b0;
      CORE_EN    <= 1'b0;
      START      <= 1'b0;
      LOAD_ERR   <= 1'b0;
      INSTR_CNT  <= 32'd0;
      DATA_CNT   <= 32'd0;
    end else begin
      state     <= state_nxt;
      RX_READY  <= loading_nxt;
      IMEM_WE   <= 1'b0;
      DMEM_WE   <= 1'b0;
      START     <= (state_nxt == S_RUN) && (state != S_RUN);
      CORE_RSTn <= (state_nxt == S_RUN);
      CORE_EN   <= (state_nxt == S_RUN);
      LOAD_ERR  <= (state_nxt == S_ERR);
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_word <= word_full;
      end
      if (word_done) begin
        case (state)
          S_I_HDR: begin
            INSTR_CNT  <= word_full;
            words_left <= word_full;
            word_idx   <= 32'd0;
          end
          S_I_WORDS: begin
            IMEM_WE    <= 1'b1;
            IMEM_ADDR  <= word_idx[IADDR_WIDTH-1:0];
            IMEM_WDATA <= word_full;
            word_idx   <= word_idx + 32'd1;
            words_left <= words_left - 32'd1;
          end
          S_D_HDR: begin
            DATA_CNT   <= word_full;
            words_left <= word_full;
            word_idx   <= 32'd0;
          end
          S_D_WORDS: begin
            DMEM_WE    <= 1'b1;
            DMEM_ADDR  <= word_idx[DADDR_WIDTH-1:0];
            DMEM_WDATA <= word_full;
            word_idx   <= word_idx + 32'd1;
            words_left <= words_left - 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of load images driven as byte streams, compared
// against a stream-parsing reference model, plus reset and post-run sequences.
module tb_prog_loader;
  localparam int AW = 4;
  localparam int unsigned LIMIT = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    RX_DATA = 8'd0;
  logic          RX_VALID = 1'b0;
  logic          RX_READY;
  logic          IMEM_WE, DMEM_WE;
  logic [AW-1:0] IMEM_ADDR, DMEM_ADDR;
  logic [31:0]   IMEM_WDATA, DMEM_WDATA;
  logic          CORE_RSTn, CORE_EN, START, LOAD_ERR;
  logic [31:0]   INSTR_CNT, DATA_CNT;

  prog_loader #(.IADDR_WIDTH(AW), .DADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR), .IMEM_WDATA(IMEM_WDATA),
    .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .CORE_RSTn(CORE_RSTn), .CORE_EN(CORE_EN), .START(START), .LOAD_ERR(LOAD_ERR),
    .INSTR_CNT(INSTR_CNT), .DATA_CNT(DATA_CNT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned ni;
    int unsigned nd;
    bit          fixed;
    bit          gap;
    bit          exp_err;
    int          exp_start;
  } vec_t;
  vec_t tbl[8];

  logic [7:0]  q[$];
  logic [63:0] exp_i[$], exp_d[$], act_i[$], act_d[$];
  logic        model_err;
  logic [31:0] exp_icnt, exp_dcnt;
  int          start_n, start_cyc, last_acc;
  logic        rstn_seen;

  always @(negedge CLK) begin
    if (IMEM_WE) act_i.push_back({28'd0, IMEM_ADDR, IMEM_WDATA});
    if (DMEM_WE) act_d.push_back({28'd0, DMEM_ADDR, DMEM_WDATA});
    if (START) begin
      start_n   = start_n + 1;
      start_cyc = cyc;
    end
    if (CORE_RSTn) rstn_seen = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push32(input logic [31:0] w);
    for (int j = 0; j < 4; j++) q.push_back(w[8*j +: 8]);
  endtask

  task automatic build(input int unsigned ni, input int unsigned nd, input bit fixed);
    q.delete();
    push32(ni);
    for (int k = 0; k < int'(ni); k++)
      push32(fixed ? ((k == 0) ? 32'h0000_0013 : 32'h0010_0093) : $urandom);
    push32(nd);
    for (int k = 0; k < int'(nd); k++)
      push32(fixed ? 32'hDEAD_BEEF : $urandom);
  endtask

  // Reference: parse the stream directly into the list of memory writes it implies.
  task automatic ref_model();
    int p = 0;
    logic [31:0] w;
    exp_i.delete(); exp_d.delete();
    model_err = 1'b0; exp_icnt = 0; exp_dcnt = 0;
    for (int sec = 0; sec < 2; sec++) begin
      logic [31:0] n;
      n = {q[p+3], q[p+2], q[p+1], q[p]}; p += 4;
      if (sec == 0) exp_icnt = n; else exp_dcnt = n;
      if (n > LIMIT) begin
        model_err = 1'b1;
        return;
      end
      for (int k = 0; k < int'(n); k++) begin
        w = {q[p+3], q[p+2], q[p+1], q[p]}; p += 4;
        if (sec == 0) exp_i.push_back({32'(k), w});
        else          exp_d.push_back({32'(k), w});
      end
    end
  endtask

  task automatic send(input bit gap);
    int  stall = 0;
    logic rdy;
    while (q.size() > 0 && stall < 40) begin
      @(negedge CLK);
      rdy = RX_READY;
      if (gap && $urandom_range(0, 1) == 0) begin
        RX_VALID = 1'b0;
        RX_DATA  = 8'($urandom);
      end else begin
        RX_VALID = 1'b1;
        RX_DATA  = q[0];
        if (rdy) begin
          void'(q.pop_front());
          last_acc = cyc + 1;
        end
      end
      if (!rdy) stall++;
    end
    @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic clear_mon();
    act_i.delete(); act_d.delete();
    start_n = 0; start_cyc = -1; rstn_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; RX_VALID = 1'b0;
    @(negedge CLK);
    clear_mon();
    RST = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_imem_n"}, act_i.size(), exp_i.size());
    for (int k = 0; k < act_i.size() && k < exp_i.size(); k++)
      chk({tag, "_imem_wr"}, act_i[k], exp_i[k]);
    chk({tag, "_dmem_n"}, act_d.size(), exp_d.size());
    for (int k = 0; k < act_d.size() && k < exp_d.size(); k++)
      chk({tag, "_dmem_wr"}, act_d[k], exp_d[k]);
  endtask

  function automatic logic any_out();
    return |{RX_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
             CORE_RSTn, CORE_EN, START, LOAD_ERR, INSTR_CNT, DATA_CNT};
  endfunction

  initial begin
    logic bad;
    tbl[0] = '{2, 1, 1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{2, 1, 1'b1, 1'b1, 1'b0, 1};
    tbl[2] = '{0, 0, 1'b0, 1'b0, 1'b0, 1};
    tbl[3] = '{0, 3, 1'b0, 1'b1, 1'b0, 1};
    tbl[4] = '{17, 0, 1'b0, 1'b0, 1'b1, 0};
    tbl[5] = '{16, 2, 1'b0, 1'b1, 1'b0, 1};
    tbl[6] = '{3, 17, 1'b0, 1'b0, 1'b1, 0};
    tbl[7] = '{5, 16, 1'b0, 1'b1, 1'b0, 1};

    clear_mon();
    repeat (2) @(negedge CLK);
    chk("reset_outputs", any_out(), 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", RX_READY, 1'b1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      build(tbl[i].ni, tbl[i].nd, tbl[i].fixed);
      ref_model();
      send(tbl[i].gap);
      repeat (5) @(negedge CLK);
      chk($sformatf("v%0d_load_err", i), LOAD_ERR, tbl[i].exp_err);
      chk($sformatf("v%0d_instr_cnt", i), INSTR_CNT, exp_icnt);
      chk($sformatf("v%0d_data_cnt", i), DATA_CNT, exp_dcnt);
      check_writes($sformatf("v%0d", i));
      chk($sformatf("v%0d_start_n", i), start_n, tbl[i].exp_start);
      if (!tbl[i].exp_err) chk($sformatf("v%0d_start_cyc", i), start_cyc, last_acc);
      chk($sformatf("v%0d_core_en", i), CORE_EN, !tbl[i].exp_err);
      chk($sformatf("v%0d_core_rstn_seen", i), rstn_seen, !tbl[i].exp_err);
      chk($sformatf("v%0d_rx_ready", i), RX_READY, 1'b0);
    end

    // Reset after two bytes of instruction word 1, with RX_VALID still high.
    do_reset();
    build(2, 1, 1'b1);
    while (q.size() > 10) void'(q.pop_back());
    send(1'b0);
    RST = 1'b1; RX_VALID = 1'b1; RX_DATA = 8'hA5;
    @(negedge CLK);
    chk("midword_reset_outputs", any_out(), 1'b0);
    RST = 1'b0; RX_VALID = 1'b0;
    clear_mon();
    build(2, 1, 1'b1);
    ref_model();
    send(1'b0);
    repeat (3) @(negedge CLK);
    check_writes("reload");
    chk("reload_start_cyc", start_cyc, last_acc);

    // Stream keeps arriving after RUN: must be ignored entirely.
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      RX_VALID = 1'b1; RX_DATA = 8'($urandom);
      @(negedge CLK);
      if (RX_READY || IMEM_WE || DMEM_WE || START || !CORE_EN || !CORE_RSTn) bad = 1'b1;
    end
    RX_VALID = 1'b0;
    chk("post_run_quiet", bad, 1'b0);
    chk("post_run_start_n", start_n, 1);
    chk("post_run_imem_n", act_i.size(), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
